debug_dump_arbiter: RTL and testbench

DEBUG_DUMP_ARBITER -- requirements
Module: debug_dump_arbiter

---
 rtl/debug_arb_pkg.sv | 17 +
 rtl/debug_rr_pick.sv | 27 ++
 rtl/debug_dump_arbiter.sv | 147 ++++++++++++++
 tb/tb_debug_dump_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/debug_arb_pkg.sv
// rtl/debug_arb_pkg.sv - shared state encoding and header sync byte for debug_dump_arbiter (optional HEADER state under DEBUG_DUMP_ARBITER_HEADER_EN)
package debug_arb_pkg;

    // First byte of the per-dump header; lets a host resynchronise on the merged stream.
    localparam logic [7:0] HEADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
`ifdef DEBUG_DUMP_ARBITER_HEADER_EN
        ST_HEADER = 3'd4,
`endif
        ST_GRANT  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DONE   = 3'd3
    } arb_state_t;

endpackage

// File: rtl/debug_rr_pick.sv
// rtl/debug_rr_pick.sv - combinational round-robin picker: first set request after ptr, wrapping
module debug_rr_pick #(
    parameter int NCH = 4,
    parameter int W   = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [W-1:0]   ptr,
    output logic [W-1:0]   idx,
    output logic           found
);

    // Scan from the farthest candidate back to ptr+1 so the nearest set bit is the one left standing.
    always_comb begin
        int j;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = NCH; k >= 1; k--) begin
            j = (int'(ptr) + k) % NCH;
            if (req[W'(j)]) begin
                idx   = W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_dump_arbiter.sv
// rtl/debug_dump_arbiter.sv - merges NCH debugger dump streams onto one byte stream; DEBUG_DUMP_ARBITER_HEADER_EN adds a 2-byte header per dump
module debug_dump_arbiter
    import debug_arb_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DUMP_BYTES = 1024
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     arm,
    input  logic [NCH-1:0]           ch_triggered,
    output logic [NCH-1:0]           ch_dump_en,
    input  logic [NCH-1:0]           ch_dump_valid,
    output logic [NCH-1:0]           ch_dump_ready,
    input  logic [8*NCH-1:0]         ch_dump_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     busy,
    output logic [$clog2(NCH)-1:0]   cur_ch
);

    localparam int CW = $clog2(NCH);
    localparam int BW = $clog2(DUMP_BYTES + 1);
    localparam logic [BW-1:0] LAST_CNT = BW'(DUMP_BYTES);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cur_ch_q, cur_ch_d;
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pick_idx;
    logic          pick_found;
    logic          stream_hs;
`ifdef DEBUG_DUMP_ARBITER_HEADER_EN
    logic [7:0]    hdr_data_q, hdr_data_d;
    logic          hdr_second_q, hdr_second_d;
`endif

    debug_rr_pick #(.NCH(NCH), .W(CW)) u_pick (
        .req   (ch_triggered),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // State, grant and counter registers; rr_ptr resets to the last channel so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cur_ch_q <= '0;
            rr_ptr_q <= CW'(NCH - 1);
            cnt_q    <= '0;
`ifdef DEBUG_DUMP_ARBITER_HEADER_EN
            hdr_data_q   <= '0;
            hdr_second_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
`ifdef DEBUG_DUMP_ARBITER_HEADER_EN
            hdr_data_q   <= hdr_data_d;
            hdr_second_q <= hdr_second_d;
`endif
        end
    end

    // Next-state and output decode; everything is forced low while resetn is held so a reset mid-dump stops ready at once.
    always_comb begin
        state_d       = state_q;
        cur_ch_d      = cur_ch_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        ch_dump_en    = '0;
        ch_dump_ready = '0;
        out_valid     = 1'b0;
        out_data      = 8'h00;
        busy          = (state_q != ST_IDLE);
        cur_ch        = cur_ch_q;
        stream_hs     = ch_dump_valid[cur_ch_q] && out_ready;
`ifdef DEBUG_DUMP_ARBITER_HEADER_EN
        hdr_data_d    = hdr_data_q;
        hdr_second_d  = hdr_second_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arm && pick_found) begin
                    cur_ch_d = pick_idx;
`ifdef DEBUG_DUMP_ARBITER_HEADER_EN
                    state_d      = ST_HEADER;
                    hdr_data_d   = HEADER_SYNC;
                    hdr_second_d = 1'b0;
`else
                    state_d  = ST_GRANT;
`endif
                end
            end
`ifdef DEBUG_DUMP_ARBITER_HEADER_EN
            ST_HEADER: begin
                out_valid = 1'b1;
                out_data  = hdr_data_q;
                if (out_ready) begin
                    if (!hdr_second_q) begin
                        hdr_data_d   = 8'(cur_ch_q);
                        hdr_second_d = 1'b1;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end
            end
`endif
            ST_GRANT: begin
                ch_dump_en[cur_ch_q] = 1'b1;
                cnt_d                = '0;
                state_d              = ST_STREAM;
            end
            ST_STREAM: begin
                out_valid               = ch_dump_valid[cur_ch_q];
                out_data                = ch_dump_data[{cur_ch_q, 3'b000} +: 8];
                ch_dump_ready[cur_ch_q] = out_ready;
                if (stream_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                rr_ptr_d = cur_ch_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!resetn) begin
            ch_dump_en    = '0;
            ch_dump_ready = '0;
            out_valid     = 1'b0;
            out_data      = 8'h00;
            busy          = 1'b0;
            cur_ch        = '0;
        end
    end

endmodule

// File: tb/tb_debug_dump_arbiter.sv
// tb/tb_debug_dump_arbiter.sv - directed self-checking bench for debug_dump_arbiter
module tb_debug_dump_arbiter;

    localparam int NCH = 4;
    localparam int DB  = 1024;
`ifdef DEBUG_DUMP_ARBITER_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        arm;
    logic [3:0]  ch_triggered;
    logic [3:0]  ch_dump_en;
    logic [3:0]  ch_dump_valid;
    logic [3:0]  ch_dump_ready;
    logic [31:0] ch_dump_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic [1:0]  cur_ch;

    logic [3:0]  b_trig;
    logic [3:0]  b_en;
    logic [3:0]  b_valid;
    logic [3:0]  b_rdy;
    logic [31:0] b_data;
    logic        b_ov;
    logic        b_ready;
    logic [7:0]  b_od;
    logic        b_busy;
    logic [1:0]  b_cur;

    logic [10:0] idx [NCH];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    debug_dump_arbiter #(.NCH(NCH), .DUMP_BYTES(DB)) dut (
        .clk(clk), .resetn(resetn), .arm(arm), .ch_triggered(ch_triggered),
        .ch_dump_en(ch_dump_en), .ch_dump_valid(ch_dump_valid), .ch_dump_ready(ch_dump_ready),
        .ch_dump_data(ch_dump_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .cur_ch(cur_ch)
    );

    debug_dump_arbiter #(.NCH(NCH), .DUMP_BYTES(4)) dut4 (
        .clk(clk), .resetn(resetn), .arm(1'b1), .ch_triggered(b_trig),
        .ch_dump_en(b_en), .ch_dump_valid(b_valid), .ch_dump_ready(b_rdy),
        .ch_dump_data(b_data), .out_valid(b_ov), .out_ready(b_ready),
        .out_data(b_od), .busy(b_busy), .cur_ch(b_cur)
    );

    function automatic logic [7:0] src_byte(input int ch, input int k);
        return 8'((k * 7) ^ (ch * 61) ^ (k >> 8));
    endfunction

    // Each source channel restarts its byte index on dump_en and advances on every accepted byte.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!resetn || ch_dump_en[i]) idx[i] <= '0;
            else if (ch_dump_valid[i] && ch_dump_ready[i]) idx[i] <= idx[i] + 1'b1;
        end
    end

    always_comb begin
        ch_dump_data = '0;
        for (int i = 0; i < NCH; i++) ch_dump_data[8*i +: 8] = src_byte(i, int'(idx[i]));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Follows one dump of exp_ch; stop>0 leaves after that many data bytes.
    task automatic run_dump(input string tag, input int exp_ch, input bit stall, input bit one_shot, input int stop);
        int k = 0, errs = 0, en_own = 0, en_other = 0;
        bit seen = 0, ended = 0, quit = 0;
        logic [3:0] mask;
        logic [7:0] exp_b;
        mask = 4'(1 << exp_ch);
        for (int cyc = 0; cyc < 6000 && !ended && !quit; cyc++) begin
            @(negedge clk);
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (!seen && busy) begin
                seen = 1;
                check({tag, "_grant_ch"}, 32'(cur_ch), 32'(exp_ch));
                if (one_shot) ch_triggered = '0;
            end
            if (seen) begin
                en_own   += int'(ch_dump_en[exp_ch]);
                en_other += $countones(ch_dump_en & ~mask) + $countones(ch_dump_ready & ~mask);
                if (out_valid && out_ready) begin
                    if (k < HDR) exp_b = (k == 0) ? 8'hA5 : 8'(exp_ch);
                    else         exp_b = src_byte(exp_ch, k - HDR);
                    if (out_data !== exp_b) errs++;
                    k++;
                    if (stop > 0 && k == stop + HDR) quit = 1;
                end
                if (!busy) ended = 1;
            end
        end
        check({tag, "_byte_errs"}, 32'(errs), 0);
        check({tag, "_en_pulses"}, 32'(en_own), 1);
        check({tag, "_foreign_en_rdy"}, 32'(en_other), 0);
        if (stop > 0) begin
            check({tag, "_partial_bytes"}, 32'(k), 32'(stop + HDR));
        end else begin
            check({tag, "_busy_fell"}, 32'(ended), 1);
            check({tag, "_byte_count"}, 32'(k), 32'(DB + HDR));
        end
    endtask

    initial begin
        int bad, first, hs, d33, cur_seen;
        resetn = 1'b0; arm = 1'b0; ch_triggered = '0; ch_dump_valid = 4'hF; out_ready = 1'b0;
        b_trig = '0; b_valid = 4'hF; b_data = 32'h33221100; b_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_cur_ch", 32'(cur_ch), 0);
        check("rst_dump_en", 32'(ch_dump_en), 0);
        check("rst_dump_ready", 32'(ch_dump_ready), 0);
        check("rst_out_data", 32'(out_data), 0);
        resetn = 1'b1;

        // arm low: a trigger must not start anything
        ch_triggered = 4'b0001;
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (busy || (|ch_dump_en)) bad++;
        end
        check("disarmed_activity", 32'(bad), 0);
        ch_triggered = '0;
        arm = 1'b1;

        // all channels held triggered: rotation 0,1,2,3,0
        ch_triggered = 4'b1111;
        run_dump("rr0", 0, 0, 0, 0);
        run_dump("rr1", 1, 0, 0, 0);
        run_dump("rr2", 2, 0, 0, 0);
        run_dump("rr3", 3, 0, 0, 0);
        run_dump("rr4", 0, 0, 1, 0);

        // single channel 2, then the same dump with a randomly stalling sink
        ch_triggered = 4'b0100;
        run_dump("ch2", 2, 0, 1, 0);
        ch_triggered = 4'b0100;
        run_dump("ch2_stall", 2, 1, 1, 0);

        // reset 300 bytes into a ch1 dump
        ch_triggered = 4'b0010;
        run_dump("ch1_part", 1, 0, 1, 300);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_dump_ready", 32'(ch_dump_ready), 0);
        check("midrst_dump_en", 32'(ch_dump_en), 0);
        check("midrst_cur_ch", 32'(cur_ch), 0);
        check("midrst_out_data", 32'(out_data), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (|ch_dump_ready || out_valid || busy) bad++;
        end
        check("midrst_held_quiet", 32'(bad), 0);
        ch_triggered = 4'b0110;
        resetn = 1'b1;
        run_dump("post_rst", 1, 0, 1, 0);

        // short dump instance: 4 bytes from ch3 and the grant-to-data latency
        @(negedge clk);
        b_trig = 4'b1000;
        first = -1; hs = 0; d33 = 0; cur_seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (b_busy) begin
                b_trig = '0;
                cur_seen = int'(b_cur);
            end
            if (b_ov && first < 0) first = n;
            if (b_ov && b_ready) begin
                hs++;
                if (b_od == 8'h33) d33++;
            end
        end
        check("short_first_valid_cycle", 32'(first), (HDR > 0) ? 1 : 2);
        check("short_handshakes", 32'(hs), 32'(4 + HDR));
        check("short_ch3_bytes", 32'(d33), 4);
        check("short_cur_ch", 32'(cur_seen), 3);
        check("short_busy_end", 32'(b_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
